// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- MEM-stage load/store unit with a single-outstanding data bus.
//
// An access in EX/MEM is issued from IDLE, held on a registered bus request
// through WAIT until bus_ack (or a timeout), and its result is presented for
// one DONE cycle. A flush while the bus is busy marks the transaction killed:
// the pipeline is released immediately, and the bus cycle drains silently.
//
// Optional feature macro: ADDR_ERR_EXC_EN
//   defined   : misaligned half/word accesses raise exc_adel / exc_ades in
//               IDLE and are never issued.
//   undefined : misaligned low address bits are ignored (half/word forced
//               aligned) and the access proceeds normally.
//
// Parameters
//   BUS_TIMEOUT     WAIT cycles without ack before aborting with a bus error.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_ex_mem_op[3:0]            0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW
//   i_ex_mem_addr, i_ex_mem_wdata   byte address and store data
//   i_ex_wreg_write/addr/data   write-back request from EX/MEM
//   i_flush                     kill the current instruction
//   o_mem_wreg_write/addr/data  write-back request to MEM/WB
//   o_stallreq                  hold earlier stages while access outstanding
//   o_bus_req/we/be/addr/wdata  registered data-bus request
//   i_bus_ack, i_bus_rdata      data-bus completion
//   o_exc_adel/ades/dbe         address-error (load/store) and bus-error flags
//   o_bad_vaddr                 faulting address
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_ex_mem_op,
  input  logic [31:0] i_ex_mem_addr,
  input  logic [31:0] i_ex_mem_wdata,
  input  logic        i_ex_wreg_write,
  input  logic [4:0]  i_ex_wreg_addr,
  input  logic [31:0] i_ex_wreg_data,
  input  logic        i_flush,
  output logic        o_mem_wreg_write,
  output logic [4:0]  o_mem_wreg_addr,
  output logic [31:0] o_mem_wreg_data,
  output logic        o_stallreq,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_exc_adel,
  output logic        o_exc_ades,
  output logic        o_exc_dbe,
  output logic [31:0] o_bad_vaddr
);

  localparam int CW_RAW = $clog2(BUS_TIMEOUT + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_killed;
  logic [CW-1:0]   r_cnt;
  logic            r_berr;
  logic [31:0]     r_rdata;
  logic            r_bus_req;
  logic            r_bus_we;
  logic [3:0]      r_bus_be;
  logic [31:0]     r_bus_addr;
  logic [31:0]     r_bus_wdata;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic w_is_load, w_is_store, w_valid;
  logic w_is_byte, w_is_half, w_is_word;
  logic w_addr_err;

  assign w_is_load  = (i_ex_mem_op >= 4'd1) && (i_ex_mem_op <= 4'd5);
  assign w_is_store = (i_ex_mem_op >= 4'd6) && (i_ex_mem_op <= 4'd8);
  assign w_valid    = w_is_load || w_is_store;
  assign w_is_byte  = (i_ex_mem_op == 4'd1) || (i_ex_mem_op == 4'd2) || (i_ex_mem_op == 4'd6);
  assign w_is_half  = (i_ex_mem_op == 4'd3) || (i_ex_mem_op == 4'd4) || (i_ex_mem_op == 4'd7);
  assign w_is_word  = (i_ex_mem_op == 4'd5) || (i_ex_mem_op == 4'd8);

`ifdef ADDR_ERR_EXC_EN
  assign w_addr_err = (w_is_half && i_ex_mem_addr[0]) ||
                      (w_is_word && (i_ex_mem_addr[1:0] != 2'b00));
`else
  assign w_addr_err = 1'b0;
`endif

  // Byte offset of the selected lane; half/word are forced aligned so the
  // low address bits never matter when address errors are not trapped.
  logic [1:0] w_off;
  always_comb begin
    w_off = 2'b00;
    if (w_is_byte)      w_off = i_ex_mem_addr[1:0];
    else if (w_is_half) w_off = {i_ex_mem_addr[1], 1'b0};
  end

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    if (w_is_byte) begin
      w_be    = 4'b0001 << i_ex_mem_addr[1:0];
      w_wdata = {4{i_ex_mem_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = i_ex_mem_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_ex_mem_wdata[15:0]}};
    end else if (w_is_word) begin
      w_be    = 4'b1111;
      w_wdata = i_ex_mem_wdata;
    end
  end

  // Load lane extraction from the captured read word. EX/MEM is stalled for
  // the whole access, so the address and op are still valid in DONE.
  logic [31:0] w_shift;
  logic [31:0] w_load_data;
  assign w_shift = r_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load_data = r_rdata;
    case (i_ex_mem_op)
      4'd1:    w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      4'd2:    w_load_data = {24'h0, w_shift[7:0]};
      4'd3:    w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      4'd4:    w_load_data = {16'h0, w_shift[15:0]};
      default: w_load_data = r_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic w_timeout;
  logic w_issue;
  logic w_end;
  logic w_berr_set;
  logic w_kill_now;

  assign w_timeout  = (r_cnt == CW'(BUS_TIMEOUT - 1));
  assign w_kill_now = r_killed || i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_end        = 1'b0;
    w_berr_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid && !i_flush && !w_addr_err) begin
          w_issue      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (i_bus_ack) begin
          w_end        = 1'b1;
          w_state_next = w_kill_now ? S_IDLE : S_DONE;
        end else if (w_timeout) begin
          w_end        = 1'b1;
          w_berr_set   = !w_kill_now;
          w_state_next = w_kill_now ? S_IDLE : S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus request, counter and capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_killed    <= 1'b0;
      r_cnt       <= '0;
      r_berr      <= 1'b0;
      r_rdata     <= 32'h0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
    end else if (w_issue) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= w_is_store;
      r_bus_be    <= w_be;
      r_bus_addr  <= {i_ex_mem_addr[31:2], 2'b00};
      r_bus_wdata <= w_wdata;
      r_cnt       <= '0;
      r_berr      <= 1'b0;
      r_killed    <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (w_end) begin
        // Bus outputs return to zero so an idle bus never shows stale values.
        r_bus_req   <= 1'b0;
        r_bus_we    <= 1'b0;
        r_bus_be    <= 4'b0000;
        r_bus_addr  <= 32'h0;
        r_bus_wdata <= 32'h0;
        r_cnt       <= '0;
        r_killed    <= 1'b0;
        r_berr      <= w_berr_set;
        if (i_bus_ack) r_rdata <= i_bus_rdata;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        if (i_flush) r_killed <= 1'b1;
      end
    end
  end

  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_be    = r_bus_be;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;

  // ---------------------------------------------------------------------------
  // Write-back, stall and exception outputs
  // ---------------------------------------------------------------------------
  // Reset also forces these combinational outputs low so the whole port set
  // reads zero while reset is held, independent of the EX/MEM inputs.
  always_comb begin
    o_mem_wreg_write = 1'b0;
    o_mem_wreg_addr  = 5'd0;
    o_mem_wreg_data  = 32'h0;
    o_stallreq       = 1'b0;
    o_exc_adel       = 1'b0;
    o_exc_ades       = 1'b0;
    o_exc_dbe        = 1'b0;
    o_bad_vaddr      = 32'h0;
    if (i_rst_n && !i_flush) begin
      if (!w_valid) begin
        o_mem_wreg_write = i_ex_wreg_write;
        o_mem_wreg_addr  = i_ex_wreg_addr;
        o_mem_wreg_data  = i_ex_wreg_data;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_addr_err) begin
              o_exc_adel  = w_is_load;
              o_exc_ades  = w_is_store;
              o_bad_vaddr = i_ex_mem_addr;
            end else begin
              o_stallreq = 1'b1;
            end
          end
          S_WAIT: o_stallreq = 1'b1;
          S_DONE: begin
            if (r_berr) begin
              o_exc_dbe   = 1'b1;
              o_bad_vaddr = i_ex_mem_addr;
            end else if (w_is_load) begin
              o_mem_wreg_write = i_ex_wreg_write;
              o_mem_wreg_addr  = i_ex_wreg_addr;
              o_mem_wreg_data  = w_load_data;
            end else begin
              o_mem_wreg_write = i_ex_wreg_write;
              o_mem_wreg_addr  = i_ex_wreg_addr;
              o_mem_wreg_data  = i_ex_wreg_data;
            end
          end
          default: o_stallreq = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255, is the number of WAIT cycles without bus_ack before the access is aborted with a bus error.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ex_mem_op  in  4  access code: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-005 ex_mem_addr  in  32  byte address; ex_mem_wdata  in  32  store data (low bits significant).
REQ-006 ex_wreg_write  in  1, ex_wreg_addr  in  5, ex_wreg_data  in  32  register write-back request from EX/MEM.
REQ-007 flush  in  1  kill current instruction.
REQ-008 mem_wreg_write  out  1, mem_wreg_addr  out  5, mem_wreg_data  out  32  write-back request to MEM/WB.
REQ-009 stallreq  out  1  holds stages 0-4 while an access is outstanding.
REQ-010 bus_req  out  1, bus_we  out  1, bus_be  out  4, bus_addr  out  32, bus_wdata  out  32  data-bus request.
REQ-011 bus_ack  in  1, bus_rdata  in  32  data-bus completion.
REQ-012 exc_adel  out  1, exc_ades  out  1, exc_dbe  out  1, bad_vaddr  out  32  exception flags and faulting address.

Function
REQ-013 FSM states IDLE, WAIT, DONE, plus a killed flag and an 8+ bit timeout counter.
REQ-014 NONE op: outputs pass ex_wreg_* combinationally, stallreq=0, no bus activity.
REQ-015 IDLE, valid access, no flush, no address error: next state WAIT; bus_req=1 registered from the next cycle; bus_addr={addr[31:2],2'b00}; bus_we=1 for stores, 0 for loads.
REQ-016 bus_be: byte ops 1<<addr[1:0]; half ops addr[1]?4'b1100:4'b0011; word ops 4'b1111.
REQ-017 bus_wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-018 All bus outputs stay stable while bus_req=1; bus_req drops the cycle after bus_ack is sampled high.
REQ-019 WAIT with bus_ack=1: capture bus_rdata, next state DONE; bus_ack in IDLE or DONE is ignored.
REQ-020 DONE, one cycle: stallreq=0; loads drive mem_wreg_write=ex_wreg_write and mem_wreg_data=selected lane (LB/LH sign-extended, LBU/LHU zero-extended, LW whole word); stores pass ex_wreg_*; next state IDLE.
REQ-021 stallreq=1 whenever a valid access is present and state is not DONE, including the issue cycle in IDLE.
REQ-022 Minimum latency: ack sampled in the first WAIT cycle gives a result in DONE 2 cycles after issue.
REQ-023 Timeout: counter clears on entering WAIT and increments per WAIT cycle; on reaching BUS_TIMEOUT with no ack, bus_req drops, next state DONE, and exc_dbe=1, bad_vaddr=ex_mem_addr, mem_wreg_write=0 in DONE.
REQ-024 flush in IDLE: no request issued, all outputs zero.
REQ-025 flush in WAIT: killed=1, stallreq=0 immediately, and bus_req held until ack or timeout; the FSM then returns to IDLE without a DONE cycle, with no write-back and no exc_dbe.
REQ-026 New access while killed transaction drains: stallreq=1 and it is not issued until state is IDLE.
REQ-027 Simultaneous bus_ack and timeout in the same cycle: ack wins, no exc_dbe.

Reset
REQ-028 rst low forces state IDLE, killed 0, counter 0, bus_req/bus_we 0, bus_be 0, bus_addr/bus_wdata 0, all mem_wreg_* 0, stallreq 0, exc_* 0, bad_vaddr 0.
REQ-029 Reset mid-WAIT abandons the transaction; no write-back follows.

Configuration
REQ-030 With ADDR_ERR_EXC_EN defined: a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access raises exc_adel (loads) or exc_ades (stores) combinationally in IDLE, sets bad_vaddr=ex_mem_addr, issues no bus request, and sets stallreq=0 and mem_wreg_write=0.
REQ-031 Without ADDR_ERR_EXC_EN: exc_adel/exc_ades are tied 0, the misaligned low address bits are ignored for bus_be and lane selection (forced to half/word alignment), and the access proceeds normally.

Verification
REQ-032 LB addr 0x80000003, ack after 3 cycles, rdata 0x80112233 -> bus_be 4'b1000, stallreq high 4 cycles, mem_wreg_data 0xFFFFFF80 in DONE.
REQ-033 SH addr 0x10000002, wdata 0x0000BEEF, immediate ack -> bus_we 1, bus_be 4'b1100, bus_wdata 0xBEEFBEEF, DONE 2 cycles after issue.
REQ-034 LW with BUS_TIMEOUT=4, no ack -> bus_req high 4 cycles, then exc_dbe=1, bad_vaddr=addr, mem_wreg_write=0.
REQ-035 LHU addr 0x1001 with ADDR_ERR_EXC_EN -> exc_adel=1, bus_req never asserted; without the macro -> bus_be 4'b0011, zero-extended low half.
REQ-036 flush in 2nd WAIT cycle, ack 2 cycles later, back-to-back SW queued -> stallreq drops, no write-back, and SW issues only after return to IDLE.
REQ-037 rst low during WAIT -> all outputs 0 asynchronously, IDLE after release.
